ahb_gpio_slave: RTL and testbench

AHB-Lite slave that terminates transfers from the AHB bus interface and exposes a memory-mapped GPIO register file. It covers output data, direction, a synchronised input view and per-pin edge interrupts. The block sits directly downstream of the AHB bus interface, consuming the master-driven address/control/write-data signals and returning the slave response and read data.

---
 rtl/ahb_gpio_slave.sv | 179 +++++++++++++++++
 tb/tb_ahb_gpio_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_slave.sv
// ahb_gpio_slave: AHB-Lite slave exposing a GPIO register file.
//   Registers (word offsets): 0x00 DATAIN (RO), 0x04 DATAOUT, 0x08 DIR,
//   0x0C INTEN, 0x10 INTPOL (1=rising), 0x14 INTSTAT (W1C).
// Ports:
//   hclk, hresetn             clock, async active-low reset
//   hsel/haddr/htrans/hwrite/hsize/hwdata/hready   AHB-Lite slave inputs
//   hreadyout/hresp/hrdata    AHB-Lite slave response (hrdata is a comb mux)
//   gpio_in                   asynchronous pin inputs (2-flop synchronised)
//   gpio_out/gpio_oe          pin output values / output enables
//   irq                       OR of INTSTAT, registered
// Optional feature: define GPIO_ERR_RESP_EN to give unmapped offsets and
// non-word sizes a two-cycle ERROR response; otherwise every transfer is OKAY.
module ahb_gpio_slave #(
  parameter int unsigned GPIO_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] IDX_DATAIN  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_DATAOUT = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DIR     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_INTEN   = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_INTPOL  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_INTSTAT = IDX_W'(5);

  typedef struct packed {
    logic             valid;
    logic             write;
    logic [IDX_W-1:0] idx;
  } dphase_t;

  dphase_t               dp_q;
  logic                  accept_c;
  logic                  bad_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [GPIO_WIDTH-1:0] wdata_c;
  logic [GPIO_WIDTH-1:0] dataout_q, dir_q, inten_q, intpol_q, intstat_q;
  logic [GPIO_WIDTH-1:0] sync1_q, sync_q, prev_q;
  logic [GPIO_WIDTH-1:0] rise_c, fall_c, set_c, clr_c, intstat_nxt_c;
  logic                  unused_bits;

  // Fields not decoded in every build configuration.
  assign unused_bits = ^{hsize, haddr[1:0], htrans[0], hwdata};

  assign accept_c = hsel & hready & htrans[1];

`ifdef GPIO_ERR_RESP_EN
  assign bad_c = (haddr[ADDR_WIDTH-1:2] > IDX_INTSTAT) || (hsize != 3'd2);

  // State encoding doubles as {hreadyout, hresp} so both come straight from flops.
  typedef enum logic [1:0] {
    RSP_OKAY = 2'b10,
    RSP_ERR1 = 2'b01,
    RSP_ERR2 = 2'b11
  } rsp_state_t;

  rsp_state_t state_q, state_nxt_c;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= RSP_OKAY;
    else          state_q <= state_nxt_c;
  end

  // Error response sequencing.
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      RSP_OKAY: if (accept_c && bad_c) state_nxt_c = RSP_ERR1;
      RSP_ERR1: state_nxt_c = RSP_ERR2;
      RSP_ERR2: state_nxt_c = (accept_c && bad_c) ? RSP_ERR1 : RSP_OKAY;
      default:  state_nxt_c = RSP_OKAY;
    endcase
  end

  assign hreadyout = state_q[1];
  assign hresp     = state_q[0];
`else
  assign bad_c     = 1'b0;
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
`endif

  // Data-phase capture; bad transfers are latched as not-valid so they touch nothing.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_q <= '0;
    end else if (hready) begin
      dp_q.valid <= accept_c & ~bad_c;
      dp_q.write <= hwrite;
      dp_q.idx   <= haddr[ADDR_WIDTH-1:2];
    end
  end

  assign wr_c    = dp_q.valid & dp_q.write;
  assign rd_c    = dp_q.valid & ~dp_q.write;
  assign wdata_c = hwdata[GPIO_WIDTH-1:0];

  // Input synchroniser plus one-cycle history for edge detection.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;
  assign set_c  = inten_q & ((intpol_q & rise_c) | (~intpol_q & fall_c));
  assign clr_c  = (wr_c && (dp_q.idx == IDX_INTSTAT)) ? wdata_c : '0;
  // Set is ORed in after the clear so a coincident edge survives the W1C.
  assign intstat_nxt_c = (intstat_q & ~clr_c) | set_c;

  // Register file writes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dataout_q <= '0;
      dir_q     <= '0;
      inten_q   <= '0;
      intpol_q  <= '0;
      intstat_q <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_c) begin
        case (dp_q.idx)
          IDX_DATAOUT: dataout_q <= wdata_c;
          IDX_DIR:     dir_q     <= wdata_c;
          IDX_INTEN:   inten_q   <= wdata_c;
          IDX_INTPOL:  intpol_q  <= wdata_c;
          default:     ;
        endcase
      end
      intstat_q <= intstat_nxt_c;
      irq       <= |intstat_nxt_c;
    end
  end

  assign gpio_out = dataout_q;
  assign gpio_oe  = dir_q;

  // Read mux over current register contents; zero outside a read data phase.
  always_comb begin
    hrdata = '0;
    if (rd_c) begin
      case (dp_q.idx)
        IDX_DATAIN:  hrdata = 32'(sync_q);
        IDX_DATAOUT: hrdata = 32'(dataout_q);
        IDX_DIR:     hrdata = 32'(dir_q);
        IDX_INTEN:   hrdata = 32'(inten_q);
        IDX_INTPOL:  hrdata = 32'(intpol_q);
        IDX_INTSTAT: hrdata = 32'(intstat_q);
        default:     hrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Directed bench for ahb_gpio_slave; checks both build configurations.
module tb_ahb_gpio_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        rdy, rsp;
  logic [31:0] exp_dataout;

  ahb_gpio_slave #(.GPIO_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  // Bus drivers: each starts and ends 1 time unit after a rising edge.
  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2;
  endtask

  task automatic addr_phase(input logic [11:0] a, input logic w, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = w; hsize = sz;
  endtask

  task automatic ahb_write(input logic [11:0] a, input logic [31:0] d, input logic [2:0] sz,
                           output logic ordy, output logic orsp);
    addr_phase(a, 1'b1, sz);
    @(posedge hclk); #1;
    bus_idle(); hwdata = d; ordy = hreadyout; orsp = hresp;
    @(posedge hclk); #1;
  endtask

  task automatic ahb_read(input logic [11:0] a, output logic [31:0] d,
                          output logic ordy, output logic orsp);
    addr_phase(a, 1'b0, 3'd2);
    @(posedge hclk); #1;
    bus_idle(); d = hrdata; ordy = hreadyout; orsp = hresp;
    @(posedge hclk); #1;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; bus_idle(); haddr = '0; hwdata = '0; gpio_in = '0;
    repeat (2) @(posedge hclk); #1;
    checks += 6;
    if (hreadyout !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", hreadyout); end
    if (hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
    if (gpio_out !== 16'h0) begin failures++; $display("FAIL reset_gpio_out got=%h exp=0000", gpio_out); end
    if (gpio_oe !== 16'h0) begin failures++; $display("FAIL reset_gpio_oe got=%h exp=0000", gpio_oe); end
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=00000000", hrdata); end
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    for (int i = 0; i < 6; i++) begin
      ahb_read(12'(i * 4), rd, rdy, rsp);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00000000", i, rd); end
    end
    exp_dataout = 32'h0;
  endtask

  task automatic test_dir_dataout();
    ahb_write(12'h008, 32'h0000_00FF, 3'd2, rdy, rsp);
    // DATAOUT write immediately followed by a read of DATAOUT
    addr_phase(12'h004, 1'b1, 3'd2);
    @(posedge hclk); #1;
    hwdata = 32'h0000_A5A5; addr_phase(12'h004, 1'b0, 3'd2);
    @(posedge hclk); #1;
    bus_idle();
    checks += 4;
    if (rd !== rd) ; // keep rd live for later tasks
    if (hrdata !== 32'h0000_A5A5) begin failures++; $display("FAIL b2b_read got=%h exp=0000a5a5", hrdata); end
    if (hreadyout !== 1'b1) begin failures++; $display("FAIL b2b_wait got=%b exp=1", hreadyout); end
    if (gpio_oe !== 16'h00FF) begin failures++; $display("FAIL dir_oe got=%h exp=00ff", gpio_oe); end
    if (gpio_out !== 16'hA5A5) begin failures++; $display("FAIL dataout_pins got=%h exp=a5a5", gpio_out); end
    @(posedge hclk); #1;
    // Bits above the pin count are dropped
    ahb_write(12'h004, 32'hFFFF_1234, 3'd2, rdy, rsp);
    ahb_read(12'h004, rd, rdy, rsp);
    exp_dataout = 32'h0000_1234;
    checks += 2;
    if (rd !== exp_dataout) begin failures++; $display("FAIL dataout_upper got=%h exp=%h", rd, exp_dataout); end
    if (gpio_out !== 16'h1234) begin failures++; $display("FAIL dataout_upper_pins got=%h exp=1234", gpio_out); end
  endtask

  task automatic test_datain();
    gpio_in = 16'h0003;
    addr_phase(12'h000, 1'b0, 3'd2);
    @(posedge hclk); #1;
    checks++;
    if (hrdata !== 32'h0) begin failures++; $display("FAIL datain_1clk got=%h exp=00000000", hrdata); end
    @(posedge hclk); #1;
    bus_idle();
    checks++;
    if (hrdata !== 32'h3) begin failures++; $display("FAIL datain_2clk got=%h exp=00000003", hrdata); end
    @(posedge hclk); #1;
    ahb_write(12'h000, 32'h0000_FFFF, 3'd2, rdy, rsp);
    ahb_read(12'h000, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h3) begin failures++; $display("FAIL datain_ro got=%h exp=00000003", rd); end
  endtask

  task automatic test_irq();
    gpio_in = 16'h0000; clocks(4);
    ahb_write(12'h00C, 32'h1, 3'd2, rdy, rsp);
    ahb_write(12'h010, 32'h1, 3'd2, rdy, rsp);
    gpio_in = 16'h0001;
    clocks(2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_2clk got=%b exp=0", irq); end
    clocks(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_3clk got=%b exp=1", irq); end
    ahb_read(12'h014, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL intstat_rise got=%h exp=00000001", rd); end
    ahb_write(12'h014, 32'h1, 3'd2, rdy, rsp);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    ahb_read(12'h014, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL intstat_w1c got=%h exp=00000000", rd); end
    // Rising edge lands in the W1C data-phase cycle
    gpio_in = 16'h0000; clocks(4);
    gpio_in = 16'h0001; clocks(1);
    ahb_write(12'h014, 32'h1, 3'd2, rdy, rsp);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    ahb_read(12'h014, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL intstat_set_wins got=%h exp=00000001", rd); end
    ahb_write(12'h014, 32'hFFFF, 3'd2, rdy, rsp);
    // Falling-edge polarity on pin 1
    ahb_write(12'h00C, 32'h2, 3'd2, rdy, rsp);
    ahb_write(12'h010, 32'h0, 3'd2, rdy, rsp);
    gpio_in = 16'h0003; clocks(4);
    ahb_read(12'h014, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL intstat_fall_norise got=%h exp=00000000", rd); end
    gpio_in = 16'h0001; clocks(4);
    ahb_read(12'h014, rd, rdy, rsp);
    checks += 2;
    if (rd !== 32'h2) begin failures++; $display("FAIL intstat_fall got=%h exp=00000002", rd); end
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_fall got=%b exp=1", irq); end
    ahb_write(12'h014, 32'h2, 3'd2, rdy, rsp);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall_clear got=%b exp=0", irq); end
  endtask

  task automatic test_error();
`ifdef GPIO_ERR_RESP_EN
    addr_phase(12'h020, 1'b0, 3'd2);
    @(posedge hclk); #1;
    bus_idle();
    checks += 3;
    if (hreadyout !== 1'b0) begin failures++; $display("FAIL err1_hreadyout got=%b exp=0", hreadyout); end
    if (hresp !== 1'b1) begin failures++; $display("FAIL err1_hresp got=%b exp=1", hresp); end
    if (hrdata !== 32'h0) begin failures++; $display("FAIL err_hrdata got=%h exp=00000000", hrdata); end
    @(posedge hclk); #1;
    checks += 2;
    if (hreadyout !== 1'b1) begin failures++; $display("FAIL err2_hreadyout got=%b exp=1", hreadyout); end
    if (hresp !== 1'b1) begin failures++; $display("FAIL err2_hresp got=%b exp=1", hresp); end
    @(posedge hclk); #1;
    checks++;
    if (hresp !== 1'b0) begin failures++; $display("FAIL err_done_hresp got=%b exp=0", hresp); end
    ahb_write(12'h004, 32'h0000_5678, 3'd1, rdy, rsp);
    clocks(1);
    checks++;
    if ((rdy !== 1'b0) || (rsp !== 1'b1)) begin failures++; $display("FAIL half_err got=%b%b exp=01", rdy, rsp); end
`else
    ahb_read(12'h020, rd, rdy, rsp);
    checks += 3;
    if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=00000000", rd); end
    if (rdy !== 1'b1) begin failures++; $display("FAIL unmapped_hreadyout got=%b exp=1", rdy); end
    if (rsp !== 1'b0) begin failures++; $display("FAIL unmapped_hresp got=%b exp=0", rsp); end
    ahb_write(12'h004, 32'h0000_5678, 3'd1, rdy, rsp);
    exp_dataout = 32'h0000_5678;
    checks++;
    if ((rdy !== 1'b1) || (rsp !== 1'b0)) begin failures++; $display("FAIL half_okay got=%b%b exp=10", rdy, rsp); end
`endif
    ahb_read(12'h004, rd, rdy, rsp);
    checks++;
    if (rd !== exp_dataout) begin failures++; $display("FAIL half_dataout got=%h exp=%h", rd, exp_dataout); end
  endtask

  task automatic test_reset_mid();
`ifdef GPIO_ERR_RESP_EN
    addr_phase(12'h020, 1'b0, 3'd2);
    @(posedge hclk); #1;
    bus_idle();
    hresetn = 1'b0; #1;
    checks += 3;
    if (hreadyout !== 1'b1) begin failures++; $display("FAIL rst_err1_hreadyout got=%b exp=1", hreadyout); end
    if (hresp !== 1'b0) begin failures++; $display("FAIL rst_err1_hresp got=%b exp=0", hresp); end
    if (gpio_out !== 16'h0) begin failures++; $display("FAIL rst_err1_gpio_out got=%h exp=0000", gpio_out); end
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    ahb_read(12'h004, rd, rdy, rsp);
    checks++;
    if ((rdy !== 1'b1) || (rsp !== 1'b0) || (rd !== 32'h0)) begin
      failures++; $display("FAIL rst_next_okay got=%b%b/%h exp=10/00000000", rdy, rsp, rd);
    end
`endif
    ahb_write(12'h004, 32'h0000_0077, 3'd2, rdy, rsp);
    ahb_write(12'h008, 32'h0000_000F, 3'd2, rdy, rsp);
    addr_phase(12'h004, 1'b1, 3'd2);
    @(posedge hclk); #1;
    bus_idle(); hwdata = 32'h0000_003C;
    hresetn = 1'b0; #1;
    checks += 2;
    if (gpio_out !== 16'h0) begin failures++; $display("FAIL rst_mid_gpio_out got=%h exp=0000", gpio_out); end
    if (gpio_oe !== 16'h0) begin failures++; $display("FAIL rst_mid_gpio_oe got=%h exp=0000", gpio_oe); end
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    ahb_read(12'h004, rd, rdy, rsp);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_discard got=%h exp=00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_dir_dataout();
    test_datain();
    test_irq();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
